// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the five-stage pipeline control path:
// hazard FSM states, register-file constants and the control bundle
// that drives the PC and pipeline-register enables.
package riscv_pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } pipe_state_e;

  // One bit per pipeline-register control; packed order is also the
  // order used when the bundle is viewed as a 6-bit vector.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
  } hazard_ctrl_t;

  // Free-running pipeline: everything loads, nothing is squashed.
  localparam hazard_ctrl_t CTRL_RUN = '{
    pc_write:     1'b1,
    if_id_write:  1'b1,
    if_id_flush:  1'b0,
    id_ex_write:  1'b1,
    id_ex_bubble: 1'b0,
    ex_mem_write: 1'b1
  };

  // Whole front of the pipeline held in place.
  localparam hazard_ctrl_t CTRL_FREEZE = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the bring-up stall/flush statistics.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count events, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the five-stage RISC-V core.
// Resolves memory waits, taken-branch/jump redirects and load-use
// hazards (in that priority) into PC / pipeline-register controls,
// guards data-memory waits with a watchdog and counts stalls/flushes.
//
// Memory handshake: mem_req_EX_MEM acts as valid for the MEM-stage
// access and dmem_ready as its ready; the access completes in the cycle
// both are high, and every cycle with valid high and ready low freezes
// the pipeline from PC through EX/MEM.
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int WAIT_MAX = 64,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] rs1_IF_ID,
  input  logic [REG_ADDR_W-1:0] rs2_IF_ID,
  input  logic                  use_rs1_IF_ID,
  input  logic                  use_rs2_IF_ID,
  input  logic [REG_ADDR_W-1:0] rd_ID_EX,
  input  logic                  memread_ID_EX,
  input  logic                  redirect_EX,
  input  logic                  mem_req_EX_MEM,
  input  logic                  dmem_ready,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_write,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_write,
  output logic                  mem_fault,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output pipe_state_e           state_dbg
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

  pipe_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              fault_q;
  hazard_ctrl_t      run_ctrl, ctrl;
  pipe_state_e       run_next;
  logic              load_use, mem_stall;

  // Hazard detection on the current stage contents.
  always_comb begin
    load_use = memread_ID_EX && (rd_ID_EX != REG_ZERO) &&
               ((use_rs1_IF_ID && (rs1_IF_ID == rd_ID_EX)) ||
                (use_rs2_IF_ID && (rs2_IF_ID == rd_ID_EX)));
    mem_stall = mem_req_EX_MEM && !dmem_ready;
  end

  // RUN-state resolution, also reused for the MEM_WAIT release cycle.
  // A redirect squashes the decode instruction, so it masks load-use.
  always_comb begin
    run_ctrl = CTRL_RUN;
    run_next = RUN;
    if (mem_stall) begin
      run_ctrl = CTRL_FREEZE;
      run_next = (WAIT_ONE >= WAIT_LIMIT) ? FAULT : MEM_WAIT;
    end else if (redirect_EX) begin
      run_ctrl.if_id_flush  = 1'b1;
      run_ctrl.id_ex_bubble = 1'b1;
    end else if (load_use) begin
      run_ctrl.pc_write     = 1'b0;
      run_ctrl.if_id_write  = 1'b0;
      run_ctrl.id_ex_bubble = 1'b1;
    end
  end

  // Next-state, wait-counter and Mealy output selection.
  always_comb begin
    ctrl    = CTRL_RUN;
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      RUN: begin
        ctrl    = run_ctrl;
        state_d = run_next;
        wait_d  = mem_stall ? WAIT_ONE : '0;
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          ctrl    = run_ctrl;
          state_d = RUN;
          wait_d  = '0;
        end else begin
          ctrl   = CTRL_FREEZE;
          wait_d = wait_q + WAIT_ONE;
          if (wait_d == WAIT_LIMIT) begin
            state_d = FAULT;
          end
        end
      end
      FAULT: begin
        ctrl = CTRL_FREEZE;
      end
      default: begin
        ctrl    = CTRL_RUN;
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
    // Held in reset the pipeline free-runs so the core can flush itself.
    if (!reset_n) begin
      ctrl = CTRL_RUN;
    end
  end

  // State, wait counter and sticky watchdog flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_q || (state_d == FAULT);
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_write  = ctrl.id_ex_write;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign ex_mem_write = ctrl.ex_mem_write;
  assign mem_fault    = fault_q;
  assign state_dbg    = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .clear (1'b0),
    .inc   (!ctrl.pc_write),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .clear (1'b0),
    .inc   (ctrl.if_id_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a small watchdog limit
// and narrow counters so timeout and saturation are reachable quickly.
module tb_pipeline_hazard_ctrl;
  import riscv_pipe_pkg::*;

  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 4;

  // Control vector order: pc_write, if_id_write, if_id_flush,
  // id_ex_write, id_ex_bubble, ex_mem_write.
  localparam logic [5:0] V_RUN    = 6'b110101;
  localparam logic [5:0] V_FREEZE = 6'b000000;
  localparam logic [5:0] V_REDIR  = 6'b111111;
  localparam logic [5:0] V_LDUSE  = 6'b000111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [4:0]       rs1_IF_ID, rs2_IF_ID, rd_ID_EX;
  logic             use_rs1_IF_ID, use_rs2_IF_ID, memread_ID_EX;
  logic             redirect_EX, mem_req_EX_MEM, dmem_ready;
  logic             pc_write, if_id_write, if_id_flush;
  logic             id_ex_write, id_ex_bubble, ex_mem_write, mem_fault;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  pipe_state_e      state_dbg;
  logic [5:0]       ctrl;

  assign ctrl = {pc_write, if_id_write, if_id_flush,
                 id_ex_write, id_ex_bubble, ex_mem_write};

  pipeline_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rs1_IF_ID      (rs1_IF_ID),
    .rs2_IF_ID      (rs2_IF_ID),
    .use_rs1_IF_ID  (use_rs1_IF_ID),
    .use_rs2_IF_ID  (use_rs2_IF_ID),
    .rd_ID_EX       (rd_ID_EX),
    .memread_ID_EX  (memread_ID_EX),
    .redirect_EX    (redirect_EX),
    .mem_req_EX_MEM (mem_req_EX_MEM),
    .dmem_ready     (dmem_ready),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .id_ex_write    (id_ex_write),
    .id_ex_bubble   (id_ex_bubble),
    .ex_mem_write   (ex_mem_write),
    .mem_fault      (mem_fault),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
    .state_dbg      (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    rs1_IF_ID = 5'd0; rs2_IF_ID = 5'd0; rd_ID_EX = 5'd0;
    use_rs1_IF_ID = 1'b0; use_rs2_IF_ID = 1'b0; memread_ID_EX = 1'b0;
    redirect_EX = 1'b0; mem_req_EX_MEM = 1'b0; dmem_ready = 1'b1;
  endtask

  // Advance to the next falling edge; inputs change only here.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic drive_load_use(input logic [4:0] rd, input logic [4:0] rs2);
    memread_ID_EX = 1'b1; rd_ID_EX = rd;
    rs2_IF_ID = rs2; use_rs2_IF_ID = 1'b1;
  endtask

  task automatic do_reset();
    next_cycle();
    set_idle();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    reset_n = 1'b0;
    next_cycle();
    #1;
    check("rst_ctrl", 32'(ctrl), 32'(V_RUN));
    check("rst_fault", 32'(mem_fault), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_flush", 32'(flush_cnt), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(RUN));
    // Hazards presented during reset must not reach the outputs.
    drive_load_use(5'd5, 5'd5);
    mem_req_EX_MEM = 1'b1; dmem_ready = 1'b0;
    #1;
    check("rst_mask_ctrl", 32'(ctrl), 32'(V_RUN));
    next_cycle();
    set_idle();
    reset_n = 1'b1;

    // Load-use on rs2: one stall cycle, then the bubble clears it.
    next_cycle();
    drive_load_use(5'd5, 5'd5);
    #1 check("lu_ctrl", 32'(ctrl), 32'(V_LDUSE));
    next_cycle();
    set_idle();
    #1 check("lu_release", 32'(ctrl), 32'(V_RUN));
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    // rd = x0 never stalls.
    drive_load_use(5'd0, 5'd0);
    #1 check("lu_x0_ctrl", 32'(ctrl), 32'(V_RUN));
    next_cycle();
    check("lu_x0_cnt", 32'(stall_cnt), 32'd1);
    // rs1 matches but is unused: no stall; then used: stall.
    set_idle();
    memread_ID_EX = 1'b1; rd_ID_EX = 5'd7; rs1_IF_ID = 5'd7;
    #1 check("lu_rs1_unused", 32'(ctrl), 32'(V_RUN));
    use_rs1_IF_ID = 1'b1;
    #1 check("lu_rs1_used", 32'(ctrl), 32'(V_LDUSE));
    next_cycle();
    set_idle();
    #1 check("lu_rs1_cnt", 32'(stall_cnt), 32'd2);

    // Redirect pulse, then redirect together with load-use.
    redirect_EX = 1'b1;
    #1 check("redir_ctrl", 32'(ctrl), 32'(V_REDIR));
    next_cycle();
    set_idle();
    #1 check("redir_flush_cnt", 32'(flush_cnt), 32'd1);
    redirect_EX = 1'b1;
    drive_load_use(5'd9, 5'd9);
    #1 check("redir_lu_ctrl", 32'(ctrl), 32'(V_REDIR));
    next_cycle();
    set_idle();
    #1;
    check("redir_lu_stall", 32'(stall_cnt), 32'd2);
    check("redir_lu_flush", 32'(flush_cnt), 32'd2);

    // Memory wait of 3 cycles, release on the 4th.
    do_reset();
    for (int i = 0; i < 3; i++) exp_q.push_back(V_FREEZE);
    exp_q.push_back(V_RUN);
    for (int i = 0; i < 4; i++) begin
      mem_req_EX_MEM = 1'b1;
      dmem_ready = (i == 3);
      #1 check($sformatf("mw_ctrl_%0d", i), 32'(ctrl), 32'(exp_q.pop_front()));
      next_cycle();
    end
    set_idle();
    #1;
    check("mw_state", 32'(state_dbg), 32'(RUN));
    check("mw_stall_cnt", 32'(stall_cnt), 32'd3);
    // Redirect held during a 2-cycle wait acts only on the release cycle.
    for (int i = 0; i < 3; i++) begin
      mem_req_EX_MEM = 1'b1; redirect_EX = 1'b1;
      dmem_ready = (i == 2);
      #1 check($sformatf("mw_redir_%0d", i), 32'(ctrl), 32'((i == 2) ? V_REDIR : V_FREEZE));
      next_cycle();
    end
    set_idle();
    #1;
    check("mw_redir_flush", 32'(flush_cnt), 32'd1);
    check("mw_redir_stall", 32'(stall_cnt), 32'd5);

    // Watchdog: 4 wait cycles, then FAULT.
    do_reset();
    mem_req_EX_MEM = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("wd_freeze_%0d", i), 32'(ctrl), 32'(V_FREEZE));
      check($sformatf("wd_nofault_%0d", i), 32'(mem_fault), 32'd0);
      next_cycle();
    end
    #1;
    check("wd_state", 32'(state_dbg), 32'(FAULT));
    check("wd_fault", 32'(mem_fault), 32'd1);
    dmem_ready = 1'b1;
    next_cycle();
    #1;
    check("wd_sticky_ctrl", 32'(ctrl), 32'(V_FREEZE));
    check("wd_sticky_fault", 32'(mem_fault), 32'd1);
    do_reset();
    #1;
    check("wd_rst_state", 32'(state_dbg), 32'(RUN));
    check("wd_rst_fault", 32'(mem_fault), 32'd0);

    // Saturation: 20 load-use stalls on a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      drive_load_use(5'd3, 5'd3);
      next_cycle();
      set_idle();
      next_cycle();
    end
    #1 check("sat_stall_cnt", 32'(stall_cnt), 32'd15);

    // Asynchronous reset in the middle of a memory wait.
    mem_req_EX_MEM = 1'b1; dmem_ready = 1'b0;
    next_cycle();
    next_cycle();
    #1 check("async_pre_state", 32'(state_dbg), 32'(MEM_WAIT));
    #2 reset_n = 1'b0;
    #1;
    check("async_ctrl", 32'(ctrl), 32'(V_RUN));
    check("async_state", 32'(state_dbg), 32'(RUN));
    check("async_stall", 32'(stall_cnt), 32'd0);
    check("async_fault", 32'(mem_fault), 32'd0);
    next_cycle();
    set_idle();
    reset_n = 1'b1;
    next_cycle();

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
